param_register_file: RTL

- Parametrised successor to the 64-bit/32-entry integer register file.
- Configurable width, depth and read-port count; optional hardwired-zero register; optional write-to-read bypass.
- Per-register busy scoreboard for in-flight writebacks, and a sequential post-reset clear sequence.
- Sits between decode (reads, issue) and writeback stage of the RISC-V pipeline.

---
 rtl/param_register_file_pkg.sv | 18 +
 rtl/param_register_file_if.sv | 34 +++
 rtl/param_register_file_busy_table.sv | 71 +++++++
 rtl/param_register_file.sv | 96 +++++++++
 4 files changed

// File: rtl/param_register_file_pkg.sv
// Shared types and constants for the parametrised integer register file.
package param_register_file_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_e;

    localparam int unsigned DEF_XLEN  = 64;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_NRD   = 2;

    // Low bit of read port 'port' inside a flattened multi-port bus.
    function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Decode/writeback-side bus of the register file: read ports, issue, writeback, status.
interface param_register_file_if
    import param_register_file_pkg::*;
#(
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned NRD   = DEF_NRD
) ();

    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                ready;
    logic                wb_err;

    modport master (
        output rs_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        input  rs_data, rs_busy, issue_ready, ready, wb_err
    );

    modport slave (
        input  rs_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
        output rs_data, rs_busy, issue_ready, ready, wb_err
    );

endinterface

// File: rtl/param_register_file_busy_table.sv
// Per-register in-flight writeback scoreboard: issue sets, writeback clears, sticky wb_err.
module rf_busy_table
    import param_register_file_pkg::*;
#(
    parameter int unsigned NREGS    = DEF_NREGS,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    output logic              wb_err
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_err_d;
    logic             issue_fire;
    logic             wb_fire;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Issue is applied after writeback so a same-rd pair leaves the new producer busy.
    always_comb begin
        issue_ready = run && (is_zero(issue_rd) || !busy_q[issue_rd] ||
                              (wb_valid && (wb_rd == issue_rd)));
        issue_fire  = issue_valid && issue_ready && !is_zero(issue_rd);
        wb_fire     = run && wb_valid && !is_zero(wb_rd);
        busy_d      = busy_q;
        wb_err_d    = wb_err;
        if (wb_fire) begin
            busy_d[wb_rd] = 1'b0;
            if (!busy_q[wb_rd]) begin
                wb_err_d = 1'b1;
            end
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            wb_err <= 1'b0;
        end else begin
            busy_q <= busy_d;
            wb_err <= wb_err_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        localparam int unsigned LO = port_lo(i, AW);
        logic [AW-1:0] a;
        assign a          = rs_addr[LO +: AW];
        assign rs_busy[i] = run && !is_zero(a) && busy_q[a] &&
                            !(BYPASS && wb_valid && (wb_rd == a));
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: storage, post-reset clear sequence and read muxing.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned NREGS    = DEF_NREGS,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    param_register_file_if.slave bus
);

    localparam int unsigned AW = $clog2(NREGS);

    rf_state_e       state_q;
    rf_state_e       state_d;
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   ptr_d;
    logic [XLEN-1:0] entry [NREGS];
    logic            run;

    assign run       = (state_q == RUN);
    assign bus.ready = run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(NREGS - 1)) begin
                state_d = RUN;
            end
        end
    end

    // Storage has no reset; the clear sequence zeroes it before ready rises.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            entry[ptr_q] <= '0;
        end else if (bus.wb_valid && !(ZERO_REG && (bus.wb_rd == '0))) begin
            entry[bus.wb_rd] <= bus.wb_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        localparam int unsigned ALO = port_lo(i, AW);
        localparam int unsigned DLO = port_lo(i, XLEN);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        assign a = bus.rs_addr[ALO +: AW];
        always_comb begin
            d = entry[a];
            if (!run) begin
                d = '0;
            end else if (ZERO_REG && (a == '0)) begin
                d = '0;
            end else if (BYPASS && bus.wb_valid && (bus.wb_rd == a)) begin
                d = bus.wb_data;
            end
        end
        assign bus.rs_data[DLO +: XLEN] = d;
    end

    rf_busy_table #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_busy (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .rs_addr     (bus.rs_addr),
        .rs_busy     (bus.rs_busy),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .wb_valid    (bus.wb_valid),
        .wb_rd       (bus.wb_rd),
        .wb_err      (bus.wb_err)
    );

endmodule
